// File: rtl/label_mmu.sv
`default_nettype none
// ============================================================================
// Module      : label_mmu
// Description : Label descriptor table plus address-translation responder.
//               LBSET writes (type, base, count) descriptors. Datapath MMU
//               requests (label ID, offset, required type) are answered
//               with a 16-bit physical address or a fault reason code.
//               The optional type check is enabled by defining the macro
//               LBT_TYPECHECK_EN. Without it, no type storage exists and
//               code 4 is never produced.
// Revision    : 1.0 - initial release
// ============================================================================
module label_mmu #(
    parameter int LBT_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lbt_we,
    input  logic [11:0] lbt_lbidw,
    input  logic [5:0]  lbt_typw,
    input  logic [15:0] lbt_basew,
    input  logic [15:0] lbt_countw,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] mmu_lbid,
    input  logic [15:0] mmu_ofs,
    input  logic [5:0]  mmu_reqType,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] mmu_addr,
    output logic        mmu_fault,
    output logic [2:0]  mmu_fault_code,
    output logic [7:0]  fault_cnt
);

    localparam int          IDX_W    = (LBT_DEPTH > 1) ? $clog2(LBT_DEPTH) : 1;
    localparam logic [11:0] DEPTH_12 = 12'(LBT_DEPTH);

    localparam logic [2:0] CODE_OK     = 3'd0;
    localparam logic [2:0] CODE_BADID  = 3'd1;
    localparam logic [2:0] CODE_UNSET  = 3'd2;
    localparam logic [2:0] CODE_BOUNDS = 3'd3;
`ifdef LBT_TYPECHECK_EN
    localparam logic [2:0] CODE_TYPE   = 3'd4;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Label table: valid bits are reset, data fields are not
    logic [LBT_DEPTH-1:0] tbl_valid;
    logic [15:0]          tbl_base  [LBT_DEPTH];
    logic [15:0]          tbl_count [LBT_DEPTH];
`ifdef LBT_TYPECHECK_EN
    logic [5:0]           tbl_typ   [LBT_DEPTH];
    logic [5:0]           req_type;
    logic [5:0]           ent_typ;
`else
    logic                 unused_type_inputs;
    assign unused_type_inputs = ^{lbt_typw, mmu_reqType};
`endif

    // Captured request
    logic [11:0] req_lbid;
    logic [15:0] req_ofs;

    // Write-port decode
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    assign wr_en  = lbt_we && (lbt_lbidw < DEPTH_12);
    assign wr_idx = lbt_lbidw[IDX_W-1:0];

    // Lookup datapath
    logic             lk_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic             fwd;
    logic             ent_valid;
    logic [15:0]      ent_base;
    logic [15:0]      ent_count;
    logic [2:0]       lk_code;
    logic [15:0]      lk_addr;

    // Descriptor data storage; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_base[wr_idx]  <= lbt_basew;
            tbl_count[wr_idx] <= lbt_countw;
`ifdef LBT_TYPECHECK_EN
            tbl_typ[wr_idx]   <= lbt_typw;
`endif
        end
    end

    // Valid bits: cleared by reset, set by any in-range write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_valid <= '0;
        end else if (wr_en) begin
            tbl_valid[wr_idx] <= 1'b1;
        end
    end

    // Entry read with same-cycle write forwarding, then prioritized checks
    always_comb begin
        lk_in_range = (req_lbid < DEPTH_12);
        rd_idx      = lk_in_range ? req_lbid[IDX_W-1:0] : '0;
        // An equal index can only match an in-range write
        fwd         = lbt_we && (lbt_lbidw == req_lbid);
        ent_valid   = fwd ? 1'b1       : tbl_valid[rd_idx];
        ent_base    = fwd ? lbt_basew  : tbl_base[rd_idx];
        ent_count   = fwd ? lbt_countw : tbl_count[rd_idx];
`ifdef LBT_TYPECHECK_EN
        ent_typ     = fwd ? lbt_typw   : tbl_typ[rd_idx];
`endif
        lk_code = CODE_OK;
        if (!lk_in_range) begin
            lk_code = CODE_BADID;
        end else if (!ent_valid) begin
            lk_code = CODE_UNSET;
        end else if (req_ofs >= ent_count) begin
            lk_code = CODE_BOUNDS;
`ifdef LBT_TYPECHECK_EN
        end else if ((req_type != 6'd0) && (req_type != ent_typ)) begin
            lk_code = CODE_TYPE;
`endif
        end
        lk_addr = (lk_code == CODE_OK) ? (ent_base + req_ofs) : 16'h0000;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture on acceptance
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req_valid) begin
            req_lbid <= mmu_lbid;
            req_ofs  <= mmu_ofs;
`ifdef LBT_TYPECHECK_EN
            req_type <= mmu_reqType;
`endif
        end
    end

    // Response and fault counter registered at the LOOKUP->RESP edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mmu_addr       <= 16'h0000;
            mmu_fault      <= 1'b0;
            mmu_fault_code <= 3'd0;
            fault_cnt      <= 8'd0;
        end else if (state == LOOKUP) begin
            mmu_addr       <= lk_addr;
            mmu_fault      <= (lk_code != CODE_OK);
            mmu_fault_code <= lk_code;
            if ((lk_code != CODE_OK) && (fault_cnt != 8'hFF)) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_label_mmu.sv
`default_nettype none
// ============================================================================
// Module      : tb_label_mmu
// Description : Self-checking bench for label_mmu. A reference model of the
//               label table predicts each response; predictions are queued
//               when a request is issued and compared when it completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_label_mmu;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        lbt_we;
    logic [11:0] lbt_lbidw;
    logic [5:0]  lbt_typw;
    logic [15:0] lbt_basew;
    logic [15:0] lbt_countw;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] mmu_lbid;
    logic [15:0] mmu_ofs;
    logic [5:0]  mmu_reqType;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] mmu_addr;
    logic        mmu_fault;
    logic [2:0]  mmu_fault_code;
    logic [7:0]  fault_cnt;

    label_mmu #(.LBT_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lbt_we         (lbt_we),
        .lbt_lbidw      (lbt_lbidw),
        .lbt_typw       (lbt_typw),
        .lbt_basew      (lbt_basew),
        .lbt_countw     (lbt_countw),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .mmu_lbid       (mmu_lbid),
        .mmu_ofs        (mmu_ofs),
        .mmu_reqType    (mmu_reqType),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .mmu_addr       (mmu_addr),
        .mmu_fault      (mmu_fault),
        .mmu_fault_code (mmu_fault_code),
        .fault_cnt      (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic        m_valid [DEPTH];
    logic [15:0] m_base  [DEPTH];
    logic [15:0] m_count [DEPTH];
    logic [5:0]  m_typ   [DEPTH];
    int          exp_cnt = 0;

    // Scoreboard entries: {addr[15:0], fault, code[2:0]}
    logic [19:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] model(input logic [11:0] id, input logic [15:0] ofs,
                                          input logic [5:0] rt);
        logic [2:0]  code;
        logic [15:0] addr;
        code = 3'd0;
        addr = 16'h0000;
        if (int'(id) >= DEPTH)            code = 3'd1;
        else if (!m_valid[id])            code = 3'd2;
        else if (ofs >= m_count[id])      code = 3'd3;
`ifdef LBT_TYPECHECK_EN
        else if (rt != 6'd0 && rt != m_typ[id]) code = 3'd4;
`else
        else if (rt === 6'bxxxxxx)        code = 3'd0;
`endif
        if (code == 3'd0) addr = m_base[id] + ofs;
        return {addr, (code != 3'd0), code};
    endfunction

    function automatic void model_write(input logic [11:0] id, input logic [5:0] t,
                                        input logic [15:0] b, input logic [15:0] c);
        if (int'(id) < DEPTH) begin
            m_valid[id] = 1'b1;
            m_typ[id]   = t;
            m_base[id]  = b;
            m_count[id] = c;
        end
    endfunction

    task automatic wr(input logic [11:0] id, input logic [5:0] t,
                      input logic [15:0] b, input logic [15:0] c);
        lbt_we = 1'b1; lbt_lbidw = id; lbt_typw = t; lbt_basew = b; lbt_countw = c;
        @(negedge clk);
        lbt_we = 1'b0;
        model_write(id, t, b, c);
    endtask

    // Present a request and return at the negedge inside LOOKUP
    task automatic start_req(input logic [11:0] id, input logic [15:0] ofs, input logic [5:0] rt);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; mmu_lbid = id; mmu_ofs = ofs; mmu_reqType = rt;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("req_ready_lookup", 32'(req_ready), 32'd0);
    endtask

    // Wait for the response (bounded), score it, then complete the handshake
    task automatic finish_rsp(input int n0);
        int n = n0;
        logic [19:0] e;
        while (!rsp_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check_val("latency", 32'(n), 32'd2);
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("addr", 32'(mmu_addr), 32'(e[19:4]));
            check_val("fault", 32'(mmu_fault), 32'(e[3]));
            check_val("code", 32'(mmu_fault_code), 32'(e[2:0]));
            if (e[3] && exp_cnt != 255) exp_cnt++;
            check_val("fault_cnt", 32'(fault_cnt), 32'(exp_cnt));
        end
        check_val("req_ready_resp", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_req(input logic [11:0] id, input logic [15:0] ofs, input logic [5:0] rt);
        exp_q.push_back(model(id, ofs, rt));
        start_req(id, ofs, rt);
        finish_rsp(1);
    endtask

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0; m_base[i] = '0; m_count[i] = '0; m_typ[i] = '0;
        end
        rst_n = 1'b0; lbt_we = 1'b0; lbt_lbidw = '0; lbt_typw = '0; lbt_basew = '0;
        lbt_countw = '0; req_valid = 1'b0; mmu_lbid = '0; mmu_ofs = '0;
        mmu_reqType = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_addr", 32'(mmu_addr), 32'd0);
        check_val("rst_fault", 32'(mmu_fault), 32'd0);
        check_val("rst_code", 32'(mmu_fault_code), 32'd0);
        check_val("rst_fault_cnt", 32'(fault_cnt), 32'd0);

        // Basic pass, bounds, bad ID, unset
        wr(12'd3, 6'd5, 16'h1000, 16'd16);
        do_req(12'd3, 16'd15, 6'd5);
        do_req(12'd3, 16'd16, 6'd5);
        do_req(12'd20, 16'd0, 6'd0);
        do_req(12'd7, 16'd0, 6'd0);

        // Address wrap-around
        wr(12'd4, 6'd1, 16'hFFF0, 16'h0040);
        do_req(12'd4, 16'h0020, 6'd0);

        // Type check (outcome depends on configuration) and wildcard type
        do_req(12'd3, 16'd0, 6'd6);
        do_req(12'd3, 16'd0, 6'd0);
        do_req(12'd3, 16'd0, 6'd5);

        // Zero count always faults; largest valid ID works
        wr(12'd5, 6'd2, 16'h0010, 16'd0);
        do_req(12'd5, 16'd0, 6'd0);
        wr(12'd15, 6'd7, 16'hABC0, 16'hFFFF);
        do_req(12'd15, 16'hFFFE, 6'd7);

        // Out-of-range write must not alias onto entry 0
        wr(12'd16, 6'd1, 16'h5555, 16'd8);
        do_req(12'd0, 16'd0, 6'd0);

        // Write in the LOOKUP cycle is forwarded to the check
        start_req(12'd9, 16'd1, 6'd0);
        lbt_we = 1'b1; lbt_lbidw = 12'd9; lbt_typw = 6'd3;
        lbt_basew = 16'h0200; lbt_countw = 16'd4;
        model_write(12'd9, 6'd3, 16'h0200, 16'd4);
        exp_q.push_back(model(12'd9, 16'd1, 6'd0));
        @(negedge clk);
        // Backpressure while rewriting the same entry
        lbt_basew = 16'h0300;
        for (int i = 0; i < 5; i++) begin
            check_val("hold_addr", 32'(mmu_addr), 32'h0201);
            check_val("hold_req_ready", 32'(req_ready), 32'd0);
            check_val("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        lbt_we = 1'b0;
        model_write(12'd9, 6'd3, 16'h0300, 16'd4);
        finish_rsp(2);
        do_req(12'd9, 16'd1, 6'd0);

        // Reset while a response is pending abandons it
        start_req(12'd3, 16'd0, 6'd0);
        @(negedge clk);
        check_val("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        exp_cnt = 0;
        check_val("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("mid_rst_addr", 32'(mmu_addr), 32'd0);
        check_val("mid_rst_fault_cnt", 32'(fault_cnt), 32'd0);
        do_req(12'd3, 16'd0, 6'd0);

        // Fault counter saturation
        for (int i = 0; i < 260; i++) begin
            do_req(12'(20 + (i % 3)), 16'(i), 6'd0);
        end
        check_val("fault_cnt_sat", 32'(fault_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
